// File: rtl/la_pkg.sv
// Constants shared by the logic-analyser capture path (channel_input, sample_fifo, readout).
package la_pkg;

    localparam int LA_SAMPLE_W = 32;
    localparam int LA_DROP_W   = 16;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_fifo_if.sv
// Write strobe, show-ahead drain and status bundle between the sample buffer and its neighbours.
interface sample_fifo_if
    import la_pkg::*;
#(
    parameter int DATA_W = LA_SAMPLE_W,
    parameter int DEPTH  = 16,
    parameter int DROP_W = LA_DROP_W
);
    localparam int LVL_W = level_w(DEPTH);

    logic              i_save;
    logic [DATA_W-1:0] i_data;
    logic              i_read;
    logic              o_available;
    logic [DATA_W-1:0] o_data;
    logic              o_full;
    logic [LVL_W-1:0]  o_level;
    logic              o_overflow;
    logic [DROP_W-1:0] o_dropped;

    modport master (
        output i_save, i_data, i_read,
        input  o_available, o_data, o_full, o_level, o_overflow, o_dropped
    );

    modport slave (
        input  i_save, i_data, i_read,
        output o_available, o_data, o_full, o_level, o_overflow, o_dropped
    );

endinterface

// File: rtl/sample_fifo_mem.sv
// Simple dual-port storage: synchronous write, registered read address, one-cycle read latency.
// No backpressure; the owner guarantees the write address never aliases a live read it depends on.
module sample_fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     raddr_q;

    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        raddr_q <= raddr;
    end

    assign rdata = mem[raddr_q];

endmodule

// File: rtl/sample_fifo.sv
// Show-ahead sample capture FIFO with sticky overflow and saturating drop counter; write-to-head latency 1 cycle.
// Writes are never stalled: a word arriving while full is discarded and counted, reads only pop when a word is available.
module sample_fifo
    import la_pkg::*;
#(
    parameter int DATA_W = LA_SAMPLE_W,
    parameter int DEPTH  = 16,
    parameter int DROP_W = LA_DROP_W
) (
    input  logic         i_clk,
    input  logic         mrst,
    input  logic         i_clear,
    sample_fifo_if.slave bus
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               LVL_W    = level_w(DEPTH);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [PTR_W-1:0]  ram_raddr;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_nxt;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] ram_rdata;
    logic              full_q;
    logic              overflow_q;
    logic [DROP_W-1:0] dropped_q;
    logic              flush;
    logic              avail;
    logic              push;
    logic              pop;
    logic              drop;
    logic              ram_we;

    always_comb begin
        flush      = mrst | i_clear;
        avail      = (level_q != '0);
        push       = bus.i_save & (level_q != LVL_FULL);
        pop        = bus.i_read & avail;
        drop       = bus.i_save & full_q;
        ram_we     = push & ~flush;

        rd_ptr_nxt = rd_ptr;
        if (flush) begin
            rd_ptr_nxt = '0;
        end else if (pop) begin
            rd_ptr_nxt = rd_ptr + PTR_ONE;
        end
        // RAM always pre-reads the word behind the head so a pop can refill head_q next edge.
        ram_raddr  = rd_ptr_nxt + PTR_ONE;

        level_nxt  = level_q;
        if (push && !pop) begin
            level_nxt = level_q + LVL_ONE;
        end else if (pop && !push) begin
            level_nxt = level_q - LVL_ONE;
        end
    end

    sample_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .i_clk (i_clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (bus.i_data),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (mrst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
            head_q     <= '0;
        end else if (i_clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr  <= rd_ptr_nxt;
            level_q <= level_nxt;
            full_q  <= (level_nxt == LVL_FULL);

            if (drop) begin
                overflow_q <= 1'b1;
                if (dropped_q != '1) begin
                    dropped_q <= dropped_q + DROP_W'(1);
                end
            end

            // Head refill: from RAM when a second word exists, else bypass the incoming word.
            if (pop) begin
                if (level_q > LVL_ONE) begin
                    head_q <= ram_rdata;
                end else if (push) begin
                    head_q <= bus.i_data;
                end
            end else if (!avail && push) begin
                head_q <= bus.i_data;
            end
        end
    end

    assign bus.o_available = avail;
    assign bus.o_data      = head_q;
    assign bus.o_full      = full_q;
    assign bus.o_level     = level_q;
    assign bus.o_overflow  = overflow_q;
    assign bus.o_dropped   = dropped_q;

endmodule

// File: tb/tb_sample_fifo.sv
// Randomised and directed bench for sample_fifo (DEPTH=8, DROP_W=4) against a queue-based reference.
module tb_sample_fifo;
    localparam int DW     = 32;
    localparam int DEPTH  = 8;
    localparam int DROP_W = 4;
    localparam int DMAX   = (1 << DROP_W) - 1;

    logic clk  = 1'b0;
    logic mrst = 1'b1;
    logic clr  = 1'b0;

    always #5 clk = ~clk;

    sample_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

    sample_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .i_clk   (clk),
        .mrst    (mrst),
        .i_clear (clr),
        .bus     (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference: contents as a queue, plus sticky overflow flag and saturating drop count.
    logic [DW-1:0] mq[$];
    bit            m_ovf = 1'b0;
    int            m_drop = 0;
    int            m_lvl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m_lvl = mq.size();
        if (mrst || clr) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            if (bus.i_read && m_lvl > 0) void'(mq.pop_front());
            if (bus.i_save) begin
                if (m_lvl < DEPTH) begin
                    mq.push_back(bus.i_data);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < DMAX) m_drop++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("level",     32'(bus.o_level),     mq.size());
            check("available", 32'(bus.o_available), 32'(mq.size() > 0));
            check("full",      32'(bus.o_full),      32'(mq.size() == DEPTH));
            check("overflow",  32'(bus.o_overflow),  32'(m_ovf));
            check("dropped",   32'(bus.o_dropped),   m_drop);
            if (mq.size() > 0) check("head_data", bus.o_data, mq[0]);
        end
    end

    task automatic step(input bit s, input logic [DW-1:0] d, input bit r, input bit c, input bit rs);
        bus.i_save = s;
        bus.i_data = d;
        bus.i_read = r;
        clr        = c;
        mrst       = rs;
        @(posedge clk);
        #1;
        bus.i_save = 1'b0;
        bus.i_read = 1'b0;
        clr        = 1'b0;
        mrst       = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_avail"},   32'(bus.o_available), 0);
        check({tag, "_data"},    bus.o_data, 0);
        check({tag, "_full"},    32'(bus.o_full), 0);
        check({tag, "_level"},   32'(bus.o_level), 0);
        check({tag, "_ovf"},     32'(bus.o_overflow), 0);
        check({tag, "_dropped"}, 32'(bus.o_dropped), 0);
    endtask

    initial begin
        bus.i_save = 1'b0;
        bus.i_data = '0;
        bus.i_read = 1'b0;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check_reset_state("reset");
        chk_en = 1'b1;

        // Single word in and out
        step(1, 32'hA5A5_0001, 0, 0, 0);
        check("single_avail", 32'(bus.o_available), 1);
        check("single_data",  bus.o_data, 32'hA5A5_0001);
        check("single_level", 32'(bus.o_level), 1);
        step(0, 0, 1, 0, 0);
        check("single_pop_avail", 32'(bus.o_available), 0);
        check("single_pop_level", 32'(bus.o_level), 0);

        // Fill with 1..10, two dropped, then drain
        for (int i = 1; i <= 10; i++) begin
            step(1, i, 0, 0, 0);
            if (i == 8) begin
                check("fill_full8",  32'(bus.o_full), 1);
                check("fill_level8", 32'(bus.o_level), 8);
            end
        end
        check("fill_ovf",     32'(bus.o_overflow), 1);
        check("fill_dropped", 32'(bus.o_dropped), 2);
        for (int i = 1; i <= 8; i++) begin
            check("drain_data", bus.o_data, i);
            step(0, 0, 1, 0, 0);
        end
        check("drain_avail", 32'(bus.o_available), 0);

        // Read while empty changes nothing
        step(0, 0, 1, 0, 0);
        check("empty_read_level", 32'(bus.o_level), 0);
        check("empty_read_avail", 32'(bus.o_available), 0);

        // Simultaneous push/pop at level 3, pointers wrap several times
        for (int i = 0; i < 3; i++) step(1, 100 + i, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            check("pp_data",  bus.o_data, 100 + i);
            check("pp_level", 32'(bus.o_level), 3);
            step(1, 103 + i, 1, 0, 0);
        end
        check("pp_final_data", bus.o_data, 120);

        // Clear mid-burst at level 5 with a concurrent write
        step(1, 123, 0, 0, 0);
        step(1, 124, 0, 0, 0);
        check("clr_pre_level", 32'(bus.o_level), 5);
        check("clr_pre_ovf",   32'(bus.o_overflow), 1);
        step(1, 999, 0, 1, 0);
        check("clr_level",   32'(bus.o_level), 0);
        check("clr_avail",   32'(bus.o_available), 0);
        check("clr_ovf",     32'(bus.o_overflow), 0);
        check("clr_dropped", 32'(bus.o_dropped), 0);
        check("clr_data_hold", bus.o_data, 120);

        // Full: read+write together pops but drops the write
        for (int i = 0; i < 8; i++) step(1, 200 + i, 0, 0, 0);
        check("full_full", 32'(bus.o_full), 1);
        step(1, 999, 1, 0, 0);
        check("fullrw_level",   32'(bus.o_level), 7);
        check("fullrw_dropped", 32'(bus.o_dropped), 1);
        check("fullrw_full",    32'(bus.o_full), 0);
        check("fullrw_data",    bus.o_data, 201);
        step(1, 208, 0, 0, 0);

        // Saturation of the 4-bit drop counter
        for (int i = 0; i < 20; i++) step(1, 500 + i, 0, 0, 0);
        check("sat_dropped", 32'(bus.o_dropped), 32'hF);
        step(1, 777, 0, 0, 0);
        check("sat_hold", 32'(bus.o_dropped), 32'hF);
        check("sat_head", bus.o_data, 201);

        step(0, 0, 0, 0, 1);
        check_reset_state("rst2");

        // Random phases with varying save/read bias to visit full and empty often
        for (int ph = 0; ph < 12; ph++) begin
            int ps, pr;
            ps = $urandom_range(90, 10);
            pr = $urandom_range(90, 10);
            for (int c = 0; c < 250; c++) begin
                step($urandom_range(99) < ps, $urandom, $urandom_range(99) < pr,
                     $urandom_range(199) == 0, $urandom_range(399) == 0);
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
